// File: rtl/rv32i_types_pkg.sv
// Shared RV32I pipeline types plus the byte-lane helpers used by the memory stage.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_idx_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALU    = 2'd1,
        ST_ACCESS = 2'd2
    } mem_state_t;

    function automatic logic is_aligned(input mem_size_t size, input logic [1:0] a);
        case (size)
            MEM_BYTE: return 1'b1;
            MEM_HALF: return ~a[0];
            default:  return (a == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input mem_size_t size, input logic [1:0] a);
        case (size)
            MEM_BYTE: return 4'b0001 << a;
            MEM_HALF: return 4'b0011 << {a[1], 1'b0};
            default:  return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across all lanes so the bus can pick any enabled lane.
    function automatic word_t lane_replicate(input mem_size_t size, input word_t d);
        case (size)
            MEM_BYTE: return {4{d[7:0]}};
            MEM_HALF: return {2{d[15:0]}};
            default:  return d;
        endcase
    endfunction

endpackage

// File: rtl/stage3_load_extender.sv
// Selects the addressed byte/half lane of a bus word and sign- or zero-extends it.
module stage3_load_extender
    import rv32i_types_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(rdata >> {addr_lo, 3'b000});
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (mem_size_t'(size))
            MEM_BYTE: data = zero_ext ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            MEM_HALF: data = zero_ext ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/stage3_mem_stage.sv
// Memory stage: holds one instruction from execute, runs its data-bus access and
// writes back, while feeding the forwarding unit and the load-use stall.
module stage3_mem_stage
    import rv32i_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic        flush,
    input  logic [4:0]  rs1_e,
    input  logic [4:0]  rs2_e,
    output logic        dmem_ren,
    output logic        dmem_wen,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_en,
    input  logic        dmem_busy,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  rd_m,
    output logic        reg_write,
    output logic        load,
    output logic [31:0] rd_mem_data,
    output logic        load_use_stall,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned
);

    mem_state_t state;
    reg_idx_t   h_rd;
    logic       h_rw, h_load, h_store, h_uns, h_flushed, mis_q;
    logic [1:0] h_size;
    word_t      h_result, h_sdata, load_data;

    logic access, complete, transfer, ex_mem, ex_aligned, fwd_ok;

    stage3_load_extender u_ext (
        .rdata    (dmem_rdata),
        .addr_lo  (h_result[1:0]),
        .size     (h_size),
        .zero_ext (h_uns),
        .data     (load_data)
    );

    always_comb begin
        access     = (state == ST_ACCESS);
        complete   = (state == ST_ALU) | (access & ~dmem_busy);
        ex_ready   = ~flush & (~access | ~dmem_busy);
        transfer   = ex_valid & ex_ready;
        ex_mem     = ex_load | ex_store;
        ex_aligned = is_aligned(mem_size_t'(ex_size), ex_result[1:0]);
        // x0 and squashed instructions are never visible to forwarding.
        fwd_ok     = h_rw & (h_rd != 5'd0) & ~h_flushed;
    end

    always_comb begin
        dmem_ren       = access & h_load;
        dmem_wen       = access & h_store;
        dmem_addr      = access ? {h_result[31:2], 2'b00} : 32'd0;
        dmem_byte_en   = access ? byte_enable(mem_size_t'(h_size), h_result[1:0]) : 4'd0;
        dmem_wdata     = (access & h_store) ? lane_replicate(mem_size_t'(h_size), h_sdata) : 32'd0;
        rd_m           = h_rd;
        reg_write      = (state != ST_IDLE) & fwd_ok;
        load           = access & h_load & dmem_busy & ~h_flushed;
        rd_mem_data    = (state == ST_IDLE) ? 32'd0 : ((access & h_load) ? load_data : h_result);
        load_use_stall = load & (h_rd != 5'd0) & ((h_rd == rs1_e) | (h_rd == rs2_e));
        wb_en          = complete & fwd_ok & ~flush;
        wb_rd          = h_rd;
        wb_data        = rd_mem_data;
        misaligned     = mis_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            h_rd      <= '0;
            h_rw      <= 1'b0;
            h_load    <= 1'b0;
            h_store   <= 1'b0;
            h_size    <= '0;
            h_uns     <= 1'b0;
            h_result  <= '0;
            h_sdata   <= '0;
            h_flushed <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            mis_q <= transfer & ex_mem & ~ex_aligned;
            if (transfer) begin
                h_rd      <= ex_rd;
                h_rw      <= ex_reg_write;
                h_load    <= ex_load;
                h_store   <= ex_store;
                h_size    <= ex_size;
                h_uns     <= ex_unsigned;
                h_result  <= ex_result;
                h_sdata   <= ex_store_data;
                h_flushed <= 1'b0;
                if (!ex_mem)
                    state <= ST_ALU;
                else
                    state <= ex_aligned ? ST_ACCESS : ST_IDLE;
            end else if (access & dmem_busy) begin
                // A flushed access keeps its bus request until the bus finishes.
                h_flushed <= h_flushed | flush;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_stage3_mem_stage.sv
// Randomised and directed bench for stage3_mem_stage against an instruction-level model.
module tb_stage3_mem_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ex_valid, ex_ready, ex_reg_write, ex_load, ex_store, ex_unsigned;
    logic [4:0]  ex_rd, rs1_e, rs2_e, rd_m, wb_rd;
    logic [1:0]  ex_size;
    logic [31:0] ex_result, ex_store_data, dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] rd_mem_data, wb_data;
    logic        flush, dmem_ren, dmem_wen, dmem_busy, reg_write, load, load_use_stall;
    logic        wb_en, misaligned;
    logic [3:0]  dmem_byte_en;

    always #5 CLK = ~CLK;

    stage3_mem_stage dut (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_load(ex_load), .ex_store(ex_store), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .flush(flush), .rs1_e(rs1_e), .rs2_e(rs2_e), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
        .dmem_busy(dmem_busy), .dmem_rdata(dmem_rdata), .rd_m(rd_m), .reg_write(reg_write),
        .load(load), .rd_mem_data(rd_mem_data), .load_use_stall(load_use_stall), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned)
    );

    typedef struct {
        bit          valid;
        int          kind;   // 0 ALU, 1 load, 2 store
        logic [4:0]  rd;
        bit          rw;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] res;
        logic [31:0] sd;
        bit          flushed;
        int          wait_n;
        bit          flush;
        logic [4:0]  rs1, rs2;
    } op_t;

    int          errors = 0;
    int          checks = 0;
    op_t         held;
    bit          mis_pend;
    logic [31:0] mem [64];

    logic        sn_ready, sn_ren, sn_wen, sn_load, sn_stall, sn_wb_en, sn_mis, sn_rw;
    logic [3:0]  sn_be;
    logic [4:0]  sn_wb_rd;
    logic [31:0] sn_wdata, sn_wb_data, sn_fwd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic bit aligned_f(input logic [1:0] s, input logic [1:0] a);
        return (int'(a) % nbytes(s)) == 0;
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] s, input logic [1:0] a);
        logic [3:0] m = 4'd0;
        for (int i = 0; i < nbytes(s); i++)
            if (int'(a) + i < 4) m[int'(a) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] s, input logic [31:0] d);
        if (s == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (s == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] load_f(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] s, input bit uns);
        int          n = nbytes(s);
        logic [31:0] v = w >> (8 * int'(a));
        if (n < 4) begin
            v = v & ((32'h1 << (8 * n)) - 32'h1);
            if (!uns && v[8 * n - 1]) v = v - (32'h1 << (8 * n));
        end
        return v;
    endfunction

    function automatic op_t idle_s(input logic [4:0] rs = 5'd0, input bit fl = 1'b0);
        op_t o;
        o = '{default: 0};
        o.rs1 = rs;
        o.rs2 = 5'd0;
        o.flush = fl;
        return o;
    endfunction

    function automatic op_t alu_s(input logic [4:0] rd, input logic [31:0] res);
        op_t o = idle_s();
        o.valid = 1; o.kind = 0; o.rd = rd; o.rw = 1; o.res = res;
        return o;
    endfunction

    function automatic op_t ld_s(input logic [4:0] rd, input logic [31:0] a, input logic [1:0] s,
                                 input bit uns, input int w);
        op_t o = idle_s();
        o.valid = 1; o.kind = 1; o.rd = rd; o.rw = 1; o.res = a; o.size = s; o.uns = uns;
        o.wait_n = w;
        return o;
    endfunction

    function automatic op_t st_s(input logic [31:0] a, input logic [1:0] s,
                                 input logic [31:0] d, input int w);
        op_t o = idle_s();
        o.valid = 1; o.kind = 2; o.res = a; o.size = s; o.sd = d; o.wait_n = w;
        return o;
    endfunction

    // One clock cycle: drive at negedge, compare after settling, advance the model at posedge.
    task automatic step(input op_t s);
        bit          acc, busy, ld_done, e_ready, e_load, e_fwd, e_wb, xfer;
        logic [31:0] word, e_val;
        logic [3:0]  be;
        logic [31:0] wd;
        ex_valid = s.valid; ex_rd = s.rd; ex_reg_write = s.rw;
        ex_load = (s.kind == 1); ex_store = (s.kind == 2); ex_size = s.size;
        ex_unsigned = s.uns; ex_result = s.res; ex_store_data = s.sd;
        flush = s.flush; rs1_e = s.rs1; rs2_e = s.rs2;
        acc = held.valid && held.kind != 0;
        busy = acc ? (held.wait_n > 0) : 1'($urandom % 2);
        dmem_busy = busy;
        ld_done = acc && held.kind == 1 && !busy;
        word = mem[held.res[7:2]];
        dmem_rdata = ld_done ? word : $urandom;
        #1;
        e_ready = !s.flush && !(acc && busy);
        e_load = acc && held.kind == 1 && busy && !held.flushed;
        e_fwd = held.valid && held.rw && held.rd != 5'd0 && !held.flushed;
        e_wb = held.valid && !(acc && busy) && e_fwd && !s.flush;
        e_val = (held.kind == 1) ? load_f(word, held.res[1:0], held.size, held.uns) : held.res;
        check("ex_ready", 32'(ex_ready), 32'(e_ready));
        check("dmem_ren", 32'(dmem_ren), 32'(acc && held.kind == 1));
        check("dmem_wen", 32'(dmem_wen), 32'(acc && held.kind == 2));
        check("load", 32'(load), 32'(e_load));
        check("reg_write", 32'(reg_write), 32'(e_fwd));
        check("misaligned", 32'(misaligned), 32'(mis_pend));
        check("wb_en", 32'(wb_en), 32'(e_wb));
        check("load_use_stall", 32'(load_use_stall),
              32'(e_load && held.rd != 5'd0 && (held.rd == s.rs1 || held.rd == s.rs2)));
        if (acc) begin
            check("dmem_addr", dmem_addr, {held.res[31:2], 2'b00});
            check("dmem_byte_en", 32'(dmem_byte_en), 32'(be_f(held.size, held.res[1:0])));
            if (held.kind == 2) check("dmem_wdata", dmem_wdata, wdata_f(held.size, held.sd));
        end
        if (e_fwd) check("rd_m", 32'(rd_m), 32'(held.rd));
        if (e_fwd && (held.kind == 0 || ld_done)) check("rd_mem_data", rd_mem_data, e_val);
        if (e_wb) begin
            check("wb_rd", 32'(wb_rd), 32'(held.rd));
            check("wb_data", wb_data, e_val);
        end
        sn_ready = ex_ready; sn_ren = dmem_ren; sn_wen = dmem_wen; sn_load = load;
        sn_stall = load_use_stall; sn_wb_en = wb_en; sn_mis = misaligned; sn_rw = reg_write;
        sn_be = dmem_byte_en; sn_wb_rd = wb_rd; sn_wdata = dmem_wdata; sn_wb_data = wb_data;
        sn_fwd = rd_mem_data;
        @(posedge CLK);
        xfer = s.valid && e_ready;
        if (held.valid) begin
            if (acc && busy) begin
                held.wait_n--;
                if (s.flush) held.flushed = 1;
            end else begin
                if (acc && held.kind == 2) begin
                    be = be_f(held.size, held.res[1:0]);
                    wd = wdata_f(held.size, held.sd);
                    for (int i = 0; i < 4; i++)
                        if (be[i]) mem[held.res[7:2]][8 * i +: 8] = wd[8 * i +: 8];
                end
                held.valid = 0;
            end
        end
        mis_pend = 0;
        if (xfer) begin
            if (s.kind != 0 && !aligned_f(s.size, s.res[1:0])) begin
                mis_pend = 1;
            end else begin
                held = s;
                held.flushed = 0;
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        op_t r;
        int  k;
        RST = 1'b1;
        ex_valid = 0; ex_rd = 0; ex_reg_write = 0; ex_load = 0; ex_store = 0; ex_size = 0;
        ex_unsigned = 0; ex_result = 0; ex_store_data = 0; flush = 0; rs1_e = 0; rs2_e = 0;
        dmem_busy = 0; dmem_rdata = 0;
        held = idle_s();
        mis_pend = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        repeat (2) @(negedge CLK);
        check("reset ex_ready", 32'(ex_ready), 32'd1);
        check("reset dmem_ren", 32'(dmem_ren), 32'd0);
        check("reset wb_en", 32'(wb_en), 32'd0);
        check("reset rd_m", 32'(rd_m), 32'd0);
        check("reset rd_mem_data", rd_mem_data, 32'd0);
        check("reset dmem_addr", dmem_addr, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        step(alu_s(5'd5, 32'h1234));
        step(idle_s());
        check("alu wb_en", 32'(sn_wb_en), 32'd1);
        check("alu wb_rd", 32'(sn_wb_rd), 32'd5);
        check("alu rd_mem_data", sn_fwd, 32'h1234);
        check("alu load", 32'(sn_load), 32'd0);

        mem[6'h00] = 32'h0;
        mem[6'h02] = 32'h0;
        mem[6'h40 - 6'h40] = 32'h0;
        mem[6'h3F] = 32'h0;
        mem[6'h00] = 32'h0;
        mem[(32'h103 >> 2) & 63] = 32'h80FF_FF00;
        step(ld_s(5'd4, 32'h103, 2'd0, 0, 2));
        step(idle_s());
        check("lb byte_en", 32'(sn_be), 32'b1000);
        check("lb ren", 32'(sn_ren), 32'd1);
        step(idle_s());
        step(idle_s());
        check("lb wb_en", 32'(sn_wb_en), 32'd1);
        check("lb wb_data", sn_wb_data, 32'hFFFF_FF80);

        mem[(32'h102 >> 2) & 63] = 32'h8001_0000;
        step(ld_s(5'd6, 32'h102, 2'd1, 1, 0));
        step(idle_s());
        check("lhu wb_data", sn_wb_data, 32'h0000_8001);

        step(ld_s(5'd6, 32'h101, 2'd1, 0, 0));
        step(idle_s());
        check("lh misaligned", 32'(sn_mis), 32'd1);
        check("lh ren", 32'(sn_ren), 32'd0);
        step(idle_s());
        check("lh pulse end", 32'(sn_mis), 32'd0);

        step(st_s(32'h2, 2'd0, 32'h0000_00AB, 0));
        step(idle_s());
        check("sb wen", 32'(sn_wen), 32'd1);
        check("sb byte_en", 32'(sn_be), 32'b0100);
        check("sb wdata", sn_wdata, 32'hABAB_ABAB);
        check("sb wb_en", 32'(sn_wb_en), 32'd0);

        step(ld_s(5'd3, 32'h8, 2'd2, 0, 2));
        step(idle_s(5'd3));
        check("stall busy1", 32'(sn_stall), 32'd1);
        step(idle_s(5'd3));
        check("stall busy2", 32'(sn_stall), 32'd1);
        step(idle_s(5'd3));
        check("stall done", 32'(sn_stall), 32'd0);
        step(ld_s(5'd0, 32'h8, 2'd2, 0, 2));
        step(idle_s(5'd0));
        check("stall x0", 32'(sn_stall), 32'd0);
        step(idle_s());
        step(idle_s());

        step(ld_s(5'd7, 32'hC, 2'd2, 0, 3));
        step(idle_s(5'd0, 1'b1));
        check("flush ren", 32'(sn_ren), 32'd1);
        step(idle_s());
        step(idle_s());
        check("flush ren held", 32'(sn_ren), 32'd1);
        step(idle_s());
        check("flush done ren", 32'(sn_ren), 32'd1);
        check("flush no wb", 32'(sn_wb_en), 32'd0);
        r = alu_s(5'd2, 32'h55);
        r.flush = 1;
        step(r);
        check("flush wins ready", 32'(sn_ready), 32'd0);
        step(idle_s());
        check("flush wins no wb", 32'(sn_wb_en), 32'd0);

        step(ld_s(5'd9, 32'h10, 2'd2, 0, 3));
        step(idle_s());
        dmem_busy = 1'b1;
        #3 RST = 1'b1;
        #1;
        check("rst ren", 32'(dmem_ren), 32'd0);
        check("rst reg_write", 32'(reg_write), 32'd0);
        check("rst load", 32'(load), 32'd0);
        check("rst dmem_addr", dmem_addr, 32'd0);
        check("rst rd_m", 32'(rd_m), 32'd0);
        held = idle_s();
        mis_pend = 0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        for (int n = 0; n < 600; n++) begin
            k = $urandom_range(0, 99);
            if (k < 30) begin
                r = idle_s();
            end else if (k < 60) begin
                r = alu_s(5'($urandom_range(0, 7)), $urandom);
                r.rw = 1'($urandom_range(0, 3) != 0);
            end else if (k < 80) begin
                r = ld_s(5'($urandom_range(0, 7)), $urandom_range(0, 255),
                         2'($urandom_range(0, 2)), 1'($urandom % 2), $urandom_range(0, 3));
            end else begin
                r = st_s($urandom_range(0, 255), 2'($urandom_range(0, 2)), $urandom,
                         $urandom_range(0, 3));
            end
            r.flush = ($urandom_range(0, 9) == 0);
            r.rs1 = 5'($urandom_range(0, 7));
            r.rs2 = 5'($urandom_range(0, 7));
            step(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
